// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input, instruction-memory write port and
// core/status outputs of the instruction memory boot loader.
// master = byte source / system side, slave = the loader itself.
interface imem_boot_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills the instruction memory from a byte stream while
// holding the core in reset. Stream = length byte N, 4*N little-endian data
// bytes, and (optionally) one trailing XOR checksum byte.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add the checksum state;
// without it the loader goes straight to DONE after the last word.
module imem_boot_loader #(
    parameter int DEPTH = 64,
    parameter int CW    = 8
) (
    input logic                clk,
    input logic                reset,
    imem_boot_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] widx_q, widx_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   asm_q, asm_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic rx_ready;
    logic xfer;
    logic len_bad;
    logic last_word;

    // A byte moves only when the loader is in a receiving state.
    assign xfer      = bus.rx_valid && rx_ready;
    // Zero-length or oversize images are rejected before any write happens.
    assign len_bad   = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > 32'(DEPTH));
    assign last_word = (widx_q == (len_q - CW'(1)));

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wd_d    = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (len_bad) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = CW'(bus.rx_data);
                        widx_d  = '0;
                        bcnt_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = 8'd0;
`endif
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    // Shift in from the top so the first byte ends up in [7:0].
                    asm_d  = {bus.rx_data, asm_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = {30'(widx_q), 2'b00};
                        wd_d   = {bus.rx_data, asm_q};
                        widx_d = widx_q + CW'(1);
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bcnt_q  <= 2'd0;
            asm_q   <= 24'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        rx_ready     = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        bus.cpu_hold = 1'b1;
        case (state_q)
            S_LEN, S_DATA: begin
                rx_ready = 1'b1;
                bus.busy = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                bus.busy = 1'b1;
            end
`endif
            S_DONE: begin
                bus.done     = 1'b1;
                bus.cpu_hold = 1'b0;
            end
            S_ERR: begin
                bus.error = 1'b1;
            end
            default: begin
                rx_ready = 1'b0;
            end
        endcase
    end

    assign bus.rx_ready = rx_ready;
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;

endmodule
